// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with a register alias table.
// Each request is answered one cycle later with, per source channel, either
// the operand value or the ROB tag it still waits on, and the request may
// allocate a ROB tag to its destination. Commits write values and clear
// renames whose tag matches. A flush clears every rename.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rdy                       global enable; low freezes all state/outputs
//   commit_valid/reg/tag/data ROB commit path
//   flush                     clear all busy bits, drop same-cycle request
//   req_valid/id/src_en/src_reg/has_rd/rd/rd_tag   rename/lookup request
//   resp_valid/id/busy/tag/data   registered one-cycle response
//   busy_count                registered number of busy registers
module rename_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned NSRC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          commit_valid,
  input  logic [$clog2(NREG)-1:0]       commit_reg,
  input  logic [TAG_W-1:0]              commit_tag,
  input  logic [XLEN-1:0]               commit_data,
  input  logic                          flush,
  input  logic                          req_valid,
  input  logic [TAG_W-1:0]              req_id,
  input  logic [NSRC-1:0]               req_src_en,
  input  logic [NSRC*$clog2(NREG)-1:0]  req_src_reg,
  input  logic                          req_has_rd,
  input  logic [$clog2(NREG)-1:0]       req_rd,
  input  logic [TAG_W-1:0]              req_rd_tag,
  output logic                          resp_valid,
  output logic [TAG_W-1:0]              resp_id,
  output logic [NSRC-1:0]               resp_busy,
  output logic [NSRC*TAG_W-1:0]         resp_tag,
  output logic [NSRC*XLEN-1:0]          resp_data,
  output logic [$clog2(NREG):0]         busy_count
);

  localparam int unsigned REG_W = $clog2(NREG);
  localparam int unsigned CNT_W = $clog2(NREG) + 1;

  logic [XLEN-1:0]  value_q [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] tag_nxt [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_nxt;
  logic [CNT_W-1:0] cnt_c;
  logic             accept_c;
  logic             rename_c;
  logic             commit_c;
  logic [NSRC-1:0]        busy_c;
  logic [NSRC*TAG_W-1:0]  tag_c;
  logic [NSRC*XLEN-1:0]   data_c;

  // A flush drops the request; x0 is never committed or renamed.
  assign accept_c = req_valid && !flush;
  assign rename_c = accept_c && req_has_rd && (req_rd != '0);
  assign commit_c = commit_valid && (commit_reg != '0);

  // Next-state alias table: commit clears a matching rename, a rename
  // overrides the commit, and a flush overrides everything.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 0; i < int'(NREG); i++) tag_nxt[i] = tag_q[i];
    if (commit_c && (tag_q[commit_reg] == commit_tag)) busy_nxt[commit_reg] = 1'b0;
    if (rename_c) begin
      busy_nxt[req_rd] = 1'b1;
      tag_nxt[req_rd]  = req_rd_tag;
    end
    if (flush) busy_nxt = '0;
  end

  // Population count of the next-state busy vector.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(NREG); i++) cnt_c = cnt_c + CNT_W'(busy_nxt[i]);
  end

  // Source lookup against pre-update state, with same-cycle commit bypass.
  always_comb begin
    logic [REG_W-1:0] s;
    busy_c = '0;
    tag_c  = '0;
    data_c = '0;
    s      = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      s = req_src_reg[k*REG_W +: REG_W];
      if (req_src_en[k] && (s != '0)) begin
        if (!busy_q[s]) begin
          data_c[k*XLEN +: XLEN] = value_q[s];
        end else if (commit_valid && (commit_reg == s) && (commit_tag == tag_q[s])) begin
          data_c[k*XLEN +: XLEN] = commit_data;
        end else begin
          busy_c[k]                = 1'b1;
          tag_c[k*TAG_W +: TAG_W] = tag_q[s];
        end
      end
    end
  end

  // State and registered response; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q     <= '0;
      busy_count <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_busy  <= '0;
      resp_tag   <= '0;
      resp_data  <= '0;
    end else if (rdy) begin
      if (commit_c) value_q[commit_reg] <= commit_data;
      for (int i = 0; i < int'(NREG); i++) tag_q[i] <= tag_nxt[i];
      busy_q     <= busy_nxt;
      busy_count <= cnt_c;
      resp_valid <= accept_c;
      if (accept_c) begin
        resp_id   <= req_id;
        resp_busy <= busy_c;
        resp_tag  <= tag_c;
        resp_data <= data_c;
      end
    end
  end

endmodule
